// File: rtl/apb_tan_pkg.sv
// apb_tan_pkg: shared state encoding, default register addresses and result record for the APB sweep
package apb_tan_pkg;
    localparam logic [31:0] CTRL_ADDR = 32'h0;
    localparam logic [31:0] OUT_ADDR  = 32'h4;
    typedef enum logic [2:0] {IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, STALL} state_t;
    typedef struct packed {
        logic [31:0] n;
        logic [31:0] data;
    } res_t;
endpackage

// File: rtl/apb_tan_res_fifo.sv
// apb_tan_res_fifo: first-word fall-through result buffer with count-based full/empty
//   PCLK/PRESET : clock, synchronous active-low reset
//   push/wdata  : write an entry (ignored when full unless a pop frees a slot)
//   pop         : drop the head entry (ignored when empty)
//   rdata       : head entry, zero while empty
//   count/full/empty : occupancy
module apb_tan_res_fifo import apb_tan_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     push,
    input  res_t                     wdata,
    input  logic                     pop,
    output res_t                     rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    res_t           mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic           do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rp];
    always_ff @(posedge PCLK) begin
        if (do_push) mem[wp] <= wdata;
    end
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + AW'(1) : wp;
            rp    <= do_pop ? rp + AW'(1) : rp;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/apb_tan_sweep.sv
// apb_tan_sweep: walks n over [n_first, n_last], writing each n to a completer and buffering its result
//   PCLK/PRESET          : clock, synchronous active-low reset
//   start/n_first/n_last : sweep request and inclusive range
//   busy/done/err        : sweep status, one-cycle completion and error pulses
//   res_*                : first-word fall-through result stream {n, data}
//   PSEL..PREADY         : APB requester port
module apb_tan_sweep #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] CTRL_ADDR  = apb_tan_pkg::CTRL_ADDR,
    parameter logic [31:0] OUT_ADDR   = apb_tan_pkg::OUT_ADDR,
    parameter int          TIMEOUT    = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] n_first,
    input  logic [31:0] n_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_n,
    output logic [31:0] res_data,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);
    import apb_tan_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t         state, nxt;
    logic [31:0]    n, n_nxt, n_end;
    logic [TW-1:0]  tcnt;
    logic           acc, push, fin, bad, pop, full, empty, in_acc, tmo;
    logic           room_idle, room_push, wr_ph, rd_ph;
    logic [CW-1:0]  cnt;
    res_t           wr_ent, head;
    assign pop       = res_ready && !empty;
    assign res_valid = !empty;
    assign res_n     = head.n;
    assign res_data  = head.data;
    assign wr_ent    = '{n: n, data: PRDATA};
    // space is judged on the occupancy that will exist after this cycle's push/pop
    assign room_idle = !(cnt == CW'(FIFO_DEPTH) && !pop);
    assign room_push = !(cnt == CW'(FIFO_DEPTH - 1) && !pop);
    assign in_acc    = state == WR_ACCESS || state == RD_ACCESS;
    assign tmo       = in_acc && !PREADY && tcnt == TW'(TIMEOUT - 1);
    assign wr_ph     = nxt == WR_SETUP || nxt == WR_ACCESS;
    assign rd_ph     = nxt == RD_SETUP || nxt == RD_ACCESS;
    apb_tan_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .push   (push),
        .wdata  (wr_ent),
        .pop    (pop),
        .rdata  (head),
        .count  (cnt),
        .full   (full),
        .empty  (empty)
    );
    always_comb begin
        nxt   = state;
        n_nxt = n;
        acc   = 1'b0;
        push  = 1'b0;
        fin   = 1'b0;
        bad   = 1'b0;
        case (state)
            IDLE: begin
                acc   = start && n_last >= n_first;
                bad   = start && n_last < n_first;
                nxt   = acc ? (room_idle ? WR_SETUP : STALL) : IDLE;
                n_nxt = acc ? n_first : n;
            end
            WR_SETUP:  nxt = WR_ACCESS;
            WR_ACCESS: begin
                bad = tmo;
                nxt = PREADY ? RD_SETUP : tmo ? IDLE : WR_ACCESS;
            end
            RD_SETUP:  nxt = RD_ACCESS;
            RD_ACCESS: begin
                push  = PREADY;
                fin   = PREADY && n == n_end;
                bad   = tmo;
                // equality test before increment keeps n_last = all-ones from wrapping
                n_nxt = (PREADY && !fin) ? n + 32'd1 : n;
                nxt   = (fin || tmo) ? IDLE : !PREADY ? RD_ACCESS : room_push ? WR_SETUP : STALL;
            end
            STALL:     nxt = full ? STALL : WR_SETUP;
            default:   nxt = IDLE;
        endcase
    end
    // bus and status outputs are registered from the next state so they line up with it
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state   <= IDLE;
            n       <= '0;
            n_end   <= '0;
            tcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            state   <= nxt;
            n       <= n_nxt;
            n_end   <= acc ? n_last : n_end;
            tcnt    <= (in_acc && nxt == state) ? tcnt + TW'(1) : '0;
            busy    <= nxt != IDLE;
            done    <= fin;
            err     <= bad;
            PSEL    <= wr_ph || rd_ph;
            PENABLE <= nxt == WR_ACCESS || nxt == RD_ACCESS;
            PWRITE  <= wr_ph;
            PADDR   <= wr_ph ? CTRL_ADDR : rd_ph ? OUT_ADDR : '0;
            PWDATA  <= wr_ph ? n_nxt : '0;
        end
    end
endmodule

// File: tb/tb_apb_tan_sweep.sv
// tb_apb_tan_sweep: randomized scoreboard bench for apb_tan_sweep with a +100 APB completer
module tb_apb_tan_sweep;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n_first = '0, n_last = '0;
    logic        busy, done, err, res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_n, res_data;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;

    apb_tan_sweep dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .n_first(n_first), .n_last(n_last),
        .busy(busy), .done(done), .err(err), .res_valid(res_valid), .res_ready(res_ready),
        .res_n(res_n), .res_data(res_data), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, passes = 0, cyc = 0;
    int done_cnt = 0, err_cnt = 0, done_cyc = 0, ws_cyc = 0, acc_cycles = 0;
    bit arm_ws = 0, hang = 0, rnd_ready = 0;
    int waits = 0, wcnt = 0;
    logic [31:0] last_wr = '0, s_addr = '0, s_data = '0;
    logic        s_wr = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] wr_q[$];

    always @(posedge PCLK) cyc <= cyc + 1;

    // completer: answers reads with the last written value plus 100 after 'waits' wait states
    assign PREADY = PSEL && PENABLE && !hang && wcnt >= waits;
    assign PRDATA = last_wr + 32'd100;
    always @(posedge PCLK) begin
        wcnt <= (PSEL && PENABLE && !PREADY) ? wcnt + 1 : 0;
        if (PSEL && PENABLE && PWRITE && PREADY) last_wr <= PWDATA;
    end

    always @(posedge PCLK) if (rnd_ready) begin
        #1 res_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    endtask

    // monitor: scoreboard pops, APB phase checks, pulse bookkeeping
    always @(negedge PCLK) if (cyc > 0) begin
        logic [63:0] e;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL result: got unexpected n=%0h data=%0h, required none", res_n, res_data);
            end else begin
                e = exp_q.pop_front();
                chk("result", {res_n, res_data}, e);
            end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) err_cnt++;
        if (PSEL && !PENABLE) begin
            s_addr = PADDR; s_data = PWDATA; s_wr = PWRITE;
            chk("setup_addr", PADDR, PWRITE ? 32'h0 : 32'h4);
            if (PWRITE) begin
                if (arm_ws) begin ws_cyc = cyc; arm_ws = 0; end
                if (wr_q.size() == 0) begin
                    checks++;
                    $display("FAIL wr_data: got unexpected write %0h, required none", PWDATA);
                end else chk("wr_data", PWDATA, wr_q.pop_front());
            end else chk("rd_pwdata", PWDATA, 0);
        end else if (PSEL) chk("access_hold", {PADDR, PWDATA, PWRITE}, {s_addr, s_data, s_wr});
        else chk("idle_bus", {PENABLE, PWRITE, PADDR, PWDATA}, 0);
        if (PSEL && PENABLE) acc_cycles++;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit model);
        @(posedge PCLK); #1;
        n_first = a; n_last = b; start = 1'b1;
        if (model) for (logic [32:0] k = {1'b0, a}; k <= {1'b0, b}; k++) begin
            exp_q.push_back({k[31:0], k[31:0] + 32'd100});
            wr_q.push_back(k[31:0]);
        end
        @(posedge PCLK); #1;
        start = 1'b0;
        chk("busy_after_start", busy, b >= a);
    endtask

    task automatic wait_end(input int lim, output int dd, output int de);
        int d0 = done_cnt, e0 = err_cnt;
        for (int k = 0; k < lim && done_cnt == d0 && err_cnt == e0; k++) @(negedge PCLK);
        dd = done_cnt - d0;
        de = err_cnt - e0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int dd, de, a0;
        bit found;
        // reset with start held high: must be ignored
        start = 1'b1; n_first = 32'd0; n_last = 32'd3;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_flags", {busy, done, err, res_valid, PSEL, PENABLE, PWRITE}, 0);
        chk("reset_bus", {PADDR, PWDATA}, 0);
        chk("reset_res", {res_n, res_data}, 0);
        start = 1'b0; PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("start_in_reset_ignored", busy, 0);

        // zero-wait sweep 0..4, 4 cycles per n
        waits = 0; res_ready = 1'b1; arm_ws = 1;
        issue(0, 4, 1);
        wait_end(100, dd, de);
        chk("t1_done", {dd[7:0], de[7:0]}, 16'h0100);
        chk("t1_latency", done_cyc - ws_cyc, 20);
        chk("t1_busy_low", busy, 0);
        repeat (3) @(negedge PCLK);
        chk("t1_drained", exp_q.size(), 0);

        // back-pressure: 4 results then STALL
        res_ready = 1'b0;
        issue(0, 7, 1);
        repeat (40) @(posedge PCLK);
        #1;
        chk("t2_stall_psel", PSEL, 0);
        chk("t2_stall_busy", busy, 1);
        chk("t2_stall_valid", res_valid, 1);
        chk("t2_pending", exp_q.size(), 8);
        chk("t2_head", {res_n, res_data}, exp_q[0]);
        res_ready = 1'b1;
        wait_end(200, dd, de);
        chk("t2_done", {dd[7:0], de[7:0]}, 16'h0100);
        repeat (3) @(negedge PCLK);
        chk("t2_drained", exp_q.size(), 0);

        // three wait states on every access
        waits = 3; a0 = acc_cycles;
        issue(10, 13, 1);
        wait_end(200, dd, de);
        chk("t3_done", {dd[7:0], de[7:0]}, 16'h0100);
        repeat (3) @(negedge PCLK);
        chk("t3_access_cycles", acc_cycles - a0, 32);
        chk("t3_drained", exp_q.size(), 0);
        waits = 0;

        // timeout keeps buffered results
        res_ready = 1'b0;
        issue(30, 30, 1);
        wait_end(100, dd, de);
        hang = 1; wr_q.push_back(32'd7); a0 = acc_cycles;
        issue(7, 9, 0);
        wait_end(100, dd, de);
        chk("t4_err_only", {dd[7:0], de[7:0]}, 16'h0001);
        chk("t4_access_cycles", acc_cycles - a0, 16);
        chk("t4_idle", {busy, PSEL}, 0);
        chk("t4_fifo_kept", res_valid, 1);
        hang = 0; res_ready = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_writes", wr_q.size(), 0);

        // bad range, then start while busy
        issue(5, 2, 0);
        chk("t5_err", err, 1);
        repeat (4) @(posedge PCLK);
        #1;
        chk("t5_no_apb", {PSEL, busy}, 0);
        issue(20, 22, 1);
        @(posedge PCLK); #1;
        n_first = 32'd100; n_last = 32'd200; start = 1'b1;
        @(posedge PCLK); #1;
        start = 1'b0;
        wait_end(100, dd, de);
        chk("t5_done", {dd[7:0], de[7:0]}, 16'h0100);
        repeat (3) @(negedge PCLK);
        chk("t5_drained", exp_q.size() + wr_q.size(), 0);

        // top of range terminates without wrap
        issue(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1);
        wait_end(100, dd, de);
        chk("t6_done", {dd[7:0], de[7:0]}, 16'h0100);
        repeat (3) @(negedge PCLK);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_busy", busy, 0);

        // randomized ranges, wait states and consumer
        rnd_ready = 1;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] a;
            waits = $urandom_range(0, 2);
            a = $urandom_range(0, 32'hFFFF_0000);
            issue(a, a + 32'($urandom_range(0, 4)), 1);
            wait_end(400, dd, de);
            chk("t7_done", {dd[7:0], de[7:0]}, 16'h0100);
        end
        rnd_ready = 0;
        @(posedge PCLK); #2;
        res_ready = 1'b1;
        repeat (8) @(negedge PCLK);
        chk("t7_drained", exp_q.size(), 0);

        // reset during the read access of n=2
        waits = 0; res_ready = 1'b0;
        issue(0, 5, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge PCLK);
            found = PSEL && PENABLE && !PWRITE && last_wr == 32'd2;
        end
        chk("t8_reached", found, 1);
        chk("t8_valid_before", res_valid, 1);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        chk("t8_flags", {busy, done, err, res_valid, PSEL, PENABLE, PWRITE}, 0);
        chk("t8_bus", {PADDR, PWDATA}, 0);
        chk("t8_res", {res_n, res_data}, 0);
        exp_q.delete(); wr_q.delete();
        @(posedge PCLK); #1;
        PRESET = 1'b1; res_ready = 1'b1;
        issue(40, 41, 1);
        wait_end(100, dd, de);
        chk("t8_after_done", {dd[7:0], de[7:0]}, 16'h0100);
        repeat (3) @(negedge PCLK);
        chk("t8_drained", exp_q.size() + wr_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/apb_tan_sweep.md
APB_TAN_SWEEP -- requirements
Module: apb_tan_sweep

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- FIFO_DEPTH, 4: result FIFO entries (power of 2, ≥2)
- CTRL_ADDR, 32'h0: control_reg address (n operand)
- OUT_ADDR, 32'h4: output_reg address (result)
- TIMEOUT, 16: maximum ACCESS cycles waiting for PREADY
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- PCLK  in  1  sole clock, rising edge
- PRESET  in  1  reset, synchronous, active-low
- start  in  1  one-cycle sweep request
- n_first  in  32  first n, sampled on accepted start
- n_last  in  32  last n (inclusive), sampled on accepted start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep completed
- err  out  1  one-cycle pulse, bad config or PREADY timeout
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer pops head when res_valid && res_ready
- res_n  out  32  n of head entry
- res_data  out  32  result of head entry
- PSEL, PENABLE, PWRITE  out  1 each  APB requester controls
- PADDR, PWDATA  out  32 each  APB address/write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB completer ready

Function
REQ-003 SHALL use FSM states IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, STALL.
REQ-004 IDLE: start=1 with n_last ≥ n_first (unsigned) SHALL latch n_first/n_last and go to WR_SETUP (or STALL if FIFO full) next cycle, busy=1 from that cycle.
REQ-005 IDLE: start=1 with n_last < n_first SHALL pulse err next cycle and stay IDLE; start while busy SHALL be ignored.
REQ-006 WR_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=CTRL_ADDR, PWDATA=current n; unconditional move to WR_ACCESS.
REQ-007 WR_ACCESS: PSEL=1, PENABLE=1, address/data/PWRITE held; PREADY=1 SHALL move to RD_SETUP.
REQ-008 RD_SETUP: PSEL=1, PENABLE=0, PWRITE=0, PADDR=OUT_ADDR, PWDATA=0; move to RD_ACCESS.
REQ-009 RD_ACCESS: PSEL=1, PENABLE=1; on PREADY=1 SHALL push {n, PRDATA} into FIFO at that edge.
REQ-010 After the push: n==n_last -> IDLE, done pulse the next cycle, busy=0; else n increments by 1 -> WR_SETUP if FIFO has space after this cycle's push/pop, otherwise STALL.
REQ-011 STALL: PSEL=PENABLE=0; leave to WR_SETUP the cycle after FIFO becomes non-full.
REQ-012 Outside SETUP/ACCESS states PSEL=PENABLE=0, PADDR/PWDATA=0, PWRITE=0.
REQ-013 Each ACCESS state SHALL count wait cycles; PREADY still 0 after TIMEOUT cycles -> IDLE, err pulse, no done, no push, FIFO contents kept.
REQ-014 Minimum cost per n with zero-wait completer: 4 cycles.
REQ-015 FIFO: first-word fall-through, res_n/res_data valid when res_valid=1; simultaneous push and pop SHALL leave count unchanged; pop when empty ignored.
REQ-016 n_last=32'hFFFF_FFFF SHALL terminate on equality without increment wrap issue.

Reset
REQ-017 PRESET=0 sampled on a rising edge SHALL force IDLE, empty FIFO, timeout counter 0, and next-cycle outputs busy=done=err=res_valid=0, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, res_n=res_data=0, including mid-transfer.
REQ-018 start SHALL be ignored while PRESET=0.

Structure
REQ-019 Package apb_tan_pkg SHALL hold the state enum, CTRL_ADDR/OUT_ADDR constants, and the {n, data} result struct.
REQ-020 The result buffer SHALL be a sub-module apb_tan_res_fifo (sync FIFO, count-based full/empty).

Verification
REQ-021 Bench completer returns PRDATA = last written value + 100, zero wait; sweep 0..4, res_ready=1 -> entries (0,100),(1,101),(2,102),(3,103),(4,104), done 20 cycles after first WR_SETUP.
REQ-022 Same sweep 0..7, res_ready=0 -> 4 entries, FSM in STALL with PSEL=0; raise res_ready -> remaining 4 results, order preserved.
REQ-023 Completer inserts 3 wait states per ACCESS -> phases held stable, one push per n, correct data.
REQ-024 PREADY held 0 -> err pulse after 16 ACCESS cycles, busy=0, no done, PSEL=0.
REQ-025 start with n_first=5, n_last=2 -> err pulse, no APB activity; start during sweep -> ignored.
REQ-026 PRESET low during RD_ACCESS of n=2 -> next cycle all outputs at reset values, FIFO empty.
